// File: rtl/nibble_pack_1_4.sv
// ---------------------------------------------------------------------------
// nibble_pack_1_4
//
// Sequential 1-to-4 nibble packer. Nibbles arrive over a valid/ready
// handshake and are written into slots 0..3 of a 16-bit word, where slot k is
// bits [4k+3:4k] (the same mapping as the 4-to-1 nibble mux). A full word, or
// a partial word flushed on request, is loaded into a one-entry output
// register that has its own valid/ready handshake.
//
// Parameters
//   FILL         value written into unfilled slots of a flushed partial word
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_nibble_i  input nibble
//   in_valid_i   in_nibble_i is valid
//   in_ready_o   packer accepts a nibble this cycle (combinational)
//   flush_i      level request: emit the partial word padded with FILL
//   clear_i      synchronous discard of the partial word
//   out_data_o   assembled word
//   out_count_o  number of real nibbles in out_data_o (1..4)
//   out_valid_o  out_data_o / out_count_o valid
//   out_ready_i  consumer takes the word
// ---------------------------------------------------------------------------
module nibble_pack_1_4 #(
  parameter logic [3:0] FILL = 4'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  in_nibble_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  input  logic        clear_i,
  output logic [15:0] out_data_o,
  output logic [2:0]  out_count_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [15:0] acc_q,       acc_d;
  logic [1:0]  ptr_q,       ptr_d;
  logic [15:0] out_data_q,  out_data_d;
  logic [2:0]  out_count_q, out_count_d;
  logic        out_valid_q, out_valid_d;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic slot_free;
  logic accept;
  logic complete;
  logic flush_fire;

  // The output register can take a new word when it is empty or is being
  // drained on this very edge, which is what gives bubble-free throughput.
  assign slot_free = !out_valid_q || out_ready_i;

  // Only the completing nibble (ptr==3) needs the output slot; nibbles for
  // slots 0..2 keep flowing while a word is held.
  assign in_ready_o = !clear_i && !flush_i &&
                      !((ptr_q == 2'd3) && out_valid_q && !out_ready_i);

  assign accept     = in_valid_i && in_ready_o;
  assign complete   = accept && (ptr_q == 2'd3);

  // A flush with nothing accumulated is a no-op; a flush that finds the slot
  // occupied simply waits because the request is a held level.
  assign flush_fire = !clear_i && flush_i && (ptr_q != 2'd0) && slot_free;

  // -------------------------------------------------------------------------
  // Flushed-word formation: slots below ptr keep their data, the rest get
  // FILL regardless of what acc holds there.
  // -------------------------------------------------------------------------
  logic [15:0] flush_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fill
      assign flush_word[4*gi +: 4] = (ptr_q > 2'(gi)) ? acc_q[4*gi +: 4] : FILL;
    end
  endgenerate

  // Completed word: the incoming nibble lands directly in slot 3.
  logic [15:0] full_word;
  assign full_word = {in_nibble_i, acc_q[11:0]};

  // -------------------------------------------------------------------------
  // Accumulator next state (priority clear > flush > accept)
  // -------------------------------------------------------------------------
  always_comb begin
    acc_d = acc_q;
    ptr_d = ptr_q;
    if (clear_i) begin
      acc_d = 16'h0000;
      ptr_d = 2'd0;
    end else if (flush_fire) begin
      acc_d = 16'h0000;
      ptr_d = 2'd0;
    end else if (accept) begin
      if (complete) begin
        acc_d = 16'h0000;
        ptr_d = 2'd0;
      end else begin
        acc_d[{ptr_q, 2'b00} +: 4] = in_nibble_i;
        ptr_d = ptr_q + 2'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register next state
  // -------------------------------------------------------------------------
  always_comb begin
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (flush_fire) begin
      out_data_d  = flush_word;
      out_count_d = {1'b0, ptr_q};
      out_valid_d = 1'b1;
    end else if (complete) begin
      out_data_d  = full_word;
      out_count_d = 3'd4;
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      // Data and count keep their last value after a drain.
      out_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= 16'h0000;
      ptr_q       <= 2'd0;
      out_data_q  <= 16'h0000;
      out_count_q <= 3'd0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_count_o = out_count_q;
  assign out_valid_o = out_valid_q;

endmodule
